// File: rtl/greycode_pkg.sv
// rtl/greycode_pkg.sv - shared Gray/binary helpers and sample classification for greycode_decoder
package greycode_pkg;

  localparam int GREY_MAX_W = 64;

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    HOLD = 2'd1,
    STEP = 2'd2,
    ERR  = 2'd3
  } greydec_cls_e;

  // Zero-extended inputs convert correctly at any width up to GREY_MAX_W:
  // leading zero Gray bits leave the prefix XOR untouched.
  function automatic logic [GREY_MAX_W-1:0] grey2bin(input logic [GREY_MAX_W-1:0] g);
    logic [GREY_MAX_W-1:0] b;
    b[GREY_MAX_W-1] = g[GREY_MAX_W-1];
    for (int i = GREY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [GREY_MAX_W-1:0] bin2grey(input logic [GREY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/grey2bin_conv.sv
// rtl/grey2bin_conv.sv - combinational prefix-XOR Gray-to-binary converter
module grey2bin_conv #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_grey,
  output logic [WIDTH-1:0] o_bin
);

  logic [WIDTH-1:0] w_bin;

  always_comb begin
    w_bin            = '0;
    w_bin[WIDTH-1]   = i_grey[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      w_bin[i] = w_bin[i+1] ^ i_grey[i];
    end
  end

  assign o_bin = w_bin;

endmodule

// File: rtl/greycode_decoder.sv
// rtl/greycode_decoder.sv - Gray count receiver: 2-stage convert and trajectory check
// Optional saturating error counter built when GREYDEC_ERR_CNT_EN is defined.
module greycode_decoder
  import greycode_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 grey_valid,
  input  logic [WIDTH-1:0]     grey_in,
  input  logic                 err_clr,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     bin_count,
  output logic                 step,
  output logic                 hold,
  output logic                 err,
  output logic                 synced,
  output logic                 err_sticky,
  output logic [ERR_CNT_W-1:0] err_count
);

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_grey;
  // The reference is always the last accepted binary, which is exactly what
  // bin_count shows, so one register serves both.
  logic [WIDTH-1:0] r_ref;
  logic             r_synced;
  logic             r_out_valid;
  logic             r_step;
  logic             r_hold;
  logic             r_err;
  logic             r_err_sticky;

  logic [WIDTH-1:0] w_bin;
  greydec_cls_e     w_cls;
  logic             w_err_now;

  grey2bin_conv #(.WIDTH(WIDTH)) u_conv (
    .i_grey (r_s1_grey),
    .o_bin  (w_bin)
  );

  always_comb begin
    w_cls = SYNC;
    if (r_synced) begin
      if (w_bin == r_ref) begin
        w_cls = HOLD;
      end else if (w_bin == r_ref + WIDTH'(1)) begin
        w_cls = STEP;
      end else begin
        w_cls = ERR;
      end
    end
  end

  assign w_err_now = r_s1_valid && (w_cls == ERR);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid   <= 1'b0;
      r_s1_grey    <= '0;
      r_ref        <= '0;
      r_synced     <= 1'b0;
      r_out_valid  <= 1'b0;
      r_step       <= 1'b0;
      r_hold       <= 1'b0;
      r_err        <= 1'b0;
      r_err_sticky <= 1'b0;
    end else begin
      r_s1_valid <= grey_valid;
      if (grey_valid) begin
        r_s1_grey <= grey_in;
      end
      r_out_valid <= r_s1_valid;
      r_step      <= r_s1_valid && (w_cls == STEP);
      r_hold      <= r_s1_valid && (w_cls == HOLD);
      r_err       <= w_err_now;
      // Every sample, erroring or not, becomes the new reference.
      if (r_s1_valid) begin
        r_ref    <= w_bin;
        r_synced <= 1'b1;
      end
      if (w_err_now) begin
        r_err_sticky <= 1'b1;
      end else if (err_clr) begin
        r_err_sticky <= 1'b0;
      end
    end
  end

`ifdef GREYDEC_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] r_err_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (w_err_now) begin
      if (err_clr) begin
        r_err_cnt <= ERR_CNT_W'(1);
      end else if (r_err_cnt != {ERR_CNT_W{1'b1}}) begin
        r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
      end
    end else if (err_clr) begin
      r_err_cnt <= '0;
    end
  end

  assign err_count = r_err_cnt;
`else
  assign err_count = '0;
`endif

  assign out_valid  = r_out_valid;
  assign bin_count  = r_ref;
  assign step       = r_step;
  assign hold       = r_hold;
  assign err        = r_err;
  assign synced     = r_synced;
  assign err_sticky = r_err_sticky;

endmodule

// File: tb/tb_greycode_decoder.sv
// tb/tb_greycode_decoder.sv - scoreboard bench for greycode_decoder at WIDTH=4, ERR_CNT_W=2
module tb_greycode_decoder;

  localparam int W  = 4;
  localparam int CW = 2;

  localparam logic [1:0] K_SYNC = 2'd0;
  localparam logic [1:0] K_HOLD = 2'd1;
  localparam logic [1:0] K_STEP = 2'd2;
  localparam logic [1:0] K_ERR  = 2'd3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          grey_valid = 1'b0;
  logic [W-1:0]  grey_in = '0;
  logic          err_clr = 1'b0;
  logic          out_valid;
  logic [W-1:0]  bin_count;
  logic          step;
  logic          hold;
  logic          err;
  logic          synced;
  logic          err_sticky;
  logic [CW-1:0] err_count;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic [W-1:0]  bin;
    logic          step;
    logic          hold;
    logic          err;
    logic          sticky;
    logic [CW-1:0] cnt;
    int            at;
  } exp_t;

  exp_t exp_q[$];

  greycode_decoder #(.WIDTH(W), .ERR_CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .grey_valid (grey_valid),
    .grey_in    (grey_in),
    .err_clr    (err_clr),
    .out_valid  (out_valid),
    .bin_count  (bin_count),
    .step       (step),
    .hold       (hold),
    .err        (err),
    .synced     (synced),
    .err_sticky (err_sticky),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  // Monitor: pops one expectation per out_valid and checks flags are quiet otherwise.
  always @(negedge clk) begin
    if (out_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: bin=%0d at cycle %0d with empty scoreboard", bin_count, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bin_count !== e.bin || step !== e.step || hold !== e.hold || err !== e.err ||
            synced !== 1'b1 || err_sticky !== e.sticky || err_count !== e.cnt || cyc != e.at) begin
          errors++;
          $display("FAIL result: got bin=%0d step=%b hold=%b err=%b synced=%b sticky=%b cnt=%0d cyc=%0d expected bin=%0d step=%b hold=%b err=%b synced=1 sticky=%b cnt=%0d cyc=%0d",
                   bin_count, step, hold, err, synced, err_sticky, err_count, cyc,
                   e.bin, e.step, e.hold, e.err, e.sticky, e.cnt, e.at);
        end
      end
    end else begin
      checks++;
      if ({step, hold, err} !== 3'b000) begin
        errors++;
        $display("FAIL idle_flags: got step/hold/err=%b%b%b expected 000 at cycle %0d", step, hold, err, cyc);
      end
    end
  end

  task automatic send(input logic [W-1:0] g, input logic [W-1:0] b, input logic [1:0] k,
                      input logic sticky, input logic [CW-1:0] cnt);
    exp_t e;
    e.bin    = b;
    e.step   = (k == K_STEP);
    e.hold   = (k == K_HOLD);
    e.err    = (k == K_ERR);
    e.sticky = sticky;
`ifdef GREYDEC_ERR_CNT_EN
    e.cnt    = cnt;
`else
    e.cnt    = (cnt == 2'd0) ? cnt : 2'd0;
`endif
    e.at     = cyc + 2;
    exp_q.push_back(e);
    grey_in    = g;
    grey_valid = 1'b1;
    @(posedge clk);
    #1;
    grey_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    grey_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_clr(input string name);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    chk({name, "_sticky"}, 32'(err_sticky), 32'd0);
    chk({name, "_count"}, 32'(err_count), 32'd0);
  endtask

  task automatic do_reset(input string name);
    rst        = 1'b1;
    grey_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk({name, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({name, "_bin_count"}, 32'(bin_count), 32'd0);
    chk({name, "_synced"}, 32'(synced), 32'd0);
    chk({name, "_sticky"}, 32'(err_sticky), 32'd0);
    chk({name, "_count"}, 32'(err_count), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    do_reset("reset");

    // Counting run: sync then three steps.
    send(4'b0000, 4'd0, K_SYNC, 1'b0, 2'd0);
    send(4'b0001, 4'd1, K_STEP, 1'b0, 2'd0);
    send(4'b0011, 4'd2, K_STEP, 1'b0, 2'd0);
    send(4'b0010, 4'd3, K_STEP, 1'b0, 2'd0);
    idle(3);

    // Jump to 15 is an error; 15 -> 0 wraps as a step.
    send(4'b1000, 4'd15, K_ERR,  1'b1, 2'd1);
    send(4'b0000, 4'd0,  K_STEP, 1'b1, 2'd1);
    idle(3);
    pulse_clr("clr_wrap");

    // Hold across a gap; bin_count must hold while idle.
    send(4'b0011, 4'd2, K_ERR, 1'b1, 2'd1);
    idle(3);
    chk("gap_bin_hold", 32'(bin_count), 32'd2);
    chk("gap_out_valid", 32'(out_valid), 32'd0);
    send(4'b0011, 4'd2, K_HOLD, 1'b1, 2'd1);
    idle(3);

    // Skip 1 -> 3 then resync step to 4.
    do_reset("reset_skip");
    send(4'b0001, 4'd1, K_SYNC, 1'b0, 2'd0);
    send(4'b0010, 4'd3, K_ERR,  1'b1, 2'd1);
    send(4'b0110, 4'd4, K_STEP, 1'b1, 2'd1);
    idle(3);
    pulse_clr("clr_skip");

    // Backward and repeated errors; two-bit counter saturates at 3.
    send(4'b0011, 4'd2, K_ERR, 1'b1, 2'd1);
    send(4'b0001, 4'd1, K_ERR, 1'b1, 2'd2);
    send(4'b0111, 4'd5, K_ERR, 1'b1, 2'd3);
    send(4'b0000, 4'd0, K_ERR, 1'b1, 2'd3);
    send(4'b0101, 4'd6, K_ERR, 1'b1, 2'd3);
    idle(3);

    // Reset while two samples are in flight; neither may surface.
    grey_in    = 4'b0011;
    grey_valid = 1'b1;
    @(posedge clk);
    #1;
    grey_in = 4'b0110;
    rst     = 1'b1;
    @(posedge clk);
    #1;
    rst        = 1'b0;
    grey_valid = 1'b0;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_synced", 32'(synced), 32'd0);
    chk("midrst_sticky", 32'(err_sticky), 32'd0);
    idle(3);
    chk("midrst_still_unsynced", 32'(synced), 32'd0);
    send(4'b0101, 4'd6, K_SYNC, 1'b0, 2'd0);
    idle(3);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
